instr_reader: RTL
=================

// Module: instr_reader
// PURPOSE
//  Read-side sequencer for instr_register. Walks read_pointer over a programmed address range and
//  captures each instruction_word. Recomputes the expected result from opcode/operands and flags
//  mismatches. Presents each entry on a valid/ready output stream. Sits between instr_register and
//  the checker/scoreboard.
// PARAMETERS
//  DEPTH   32   register entries; pointer wraps modulo DEPTH (must match instr_register)
//  CNT_W   16   width of err_count
// PORTS
//  clk              in   1               clock, all state on posedge
//  reset_n          in   1               asynchronous, active-low reset
//  start            in   1               1-cycle request to begin a scan (ignored while busy)
//  first_ptr        in   address_t       first entry of scan
//  last_ptr         in   address_t       last entry of scan (inclusive)
//  read_pointer     out  address_t       to instr_register.read_pointer
//  instruction_word in   instruction_t   from instr_register (combinational read)
//  out_valid        out  1               out_* fields hold a captured entry
//  out_ready        in   1               downstream accepts when out_valid&&out_ready
//  out_word         out  instruction_t   captured entry
//  out_expected     out  operand_t       recomputed result
//  out_mismatch     out  1               stored result != out_expected
//  busy             out  1               scan in progress (state != IDLE)
//  done             out  1               1-cycle pulse after last entry accepted
//  err_count        out  CNT_W           mismatches accepted in current scan, saturating
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; read_pointer, out_word, out_expected, err_count = 0;
//   out_valid, out_mismatch, busy, done = 0. Reset mid-scan aborts; no done pulse.
//  FSM IDLE -> FETCH -> CHECK -> PRESENT -> (FETCH | DONE) -> IDLE:
//   IDLE: start=1 -> latch last_ptr, read_pointer<=first_ptr, err_count<=0, go FETCH.
//   FETCH: capture instruction_word into internal reg, go CHECK.
//   CHECK: load out_word/out_expected/out_mismatch, out_valid<=1, go PRESENT.
//   PRESENT: hold all out_* stable while !out_ready. On handshake: out_valid<=0,
//    err_count+=out_mismatch (saturate at all-ones). If read_pointer==last -> DONE, else
//    read_pointer<=(read_pointer+1)%DEPTH -> FETCH.
//   DONE: done=1 for exactly one cycle, -> IDLE.
//  Latency: start to first out_valid = 3 cycles. Back-to-back entries every 3 cycles with
//   out_ready held high.
//  read_pointer changes only on start acceptance or handshake; it is stable from FETCH to PRESENT.
//  Range: last<first wraps through DEPTH-1 -> 0. first==last scans exactly one entry.
//   Full range = first=0, last=DEPTH-1.
//  Expected result (operand_t arithmetic, truncated to result field width):
//   ZERO 0 | PASSA a | PASSB b | ADD a+b | SUB a-b | MULT a*b
//   DIV  b==0 ? 0 : a/b | MOD b==0 ? 0 : a%b | POW b==0 ? 1 : a**b
//   Undefined opcode -> out_expected=0, out_mismatch=1.
//  out_mismatch = (stored result !== out_expected). Any X/Z field in the captured word forces
//   out_mismatch=1.
//  start in any state other than IDLE is ignored; the range latched at acceptance is unaffected.
//  start and reset asserted together: reset wins.
// TESTING
//  1 Reset: reset_n=0 mid-run -> all outputs 0 immediately (async), state IDLE, no done pulse.
//  2 Load 0:{ADD,3,4,7} 1:{SUB,9,2,7} 2:{DIV,5,0,0}; start first=0,last=2, out_ready=1 ->
//    3 words in order, first out_valid 3 cycles after start, mismatch=0, done once, err_count=0.
//  3 Backpressure: out_ready=0 for 5 cycles on entry 1 -> out_word/read_pointer stable,
//    entry delivered once, no skips.
//  4 Wrap: first=30, last=1 -> read_pointer sequence 30,31,0,1; done after entry 1.
//  5 Bench drives instruction_word {ADD,3,4,8}, then {POW,2,0,1} -> mismatch=1 (expected 7),
//    then mismatch=0 (expected 1); err_count=1.
//  6 start pulsed while busy with new range -> ignored; scan completes on original range;
//    a new start after done is accepted.

Source files
------------

// File: rtl/instr_reader.sv
// ============================================================================
//  Module   : instr_reader
//  Purpose  : Read-side sequencer for instr_register. It scans an address range,
//             recomputes each result and streams the checked entries out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_reader_pkg;
    typedef logic [4:0]  address_t;
    typedef logic [31:0] operand_t;
    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7,
        POW   = 4'd8
    } opcode_t;
    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        operand_t result;
    } instruction_t;
endpackage

module instr_reader
    import instr_reader_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  address_t           first_ptr,
    input  address_t           last_ptr,
    output address_t           read_pointer,
    input  instruction_t       instruction_word,
    output logic               out_valid,
    input  logic               out_ready,
    output instruction_t       out_word,
    output operand_t           out_expected,
    output logic               out_mismatch,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   err_count
);

    localparam address_t         c_last_addr = address_t'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CHECK   = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t       r_state;
    address_t     r_last;
    instruction_t r_word;
    operand_t     w_expected;
    logic         w_defined;
    logic         w_mismatch;

    // Square-and-multiply keeps the power operator synthesizable; wrap is mod 2^32.
    function automatic operand_t f_pow(input operand_t base, input operand_t ex);
        operand_t acc;
        operand_t sq;
        acc = 32'd1;
        sq  = base;
        for (int i = 0; i < 32; i++) begin
            if (ex[i]) acc = acc * sq;
            sq = sq * sq;
        end
        return acc;
    endfunction

    always_comb begin
        w_expected = '0;
        w_defined  = 1'b1;
        case (r_word.opc)
            ZERO:    w_expected = '0;
            PASSA:   w_expected = r_word.op_a;
            PASSB:   w_expected = r_word.op_b;
            ADD:     w_expected = r_word.op_a + r_word.op_b;
            SUB:     w_expected = r_word.op_a - r_word.op_b;
            MULT:    w_expected = r_word.op_a * r_word.op_b;
            DIV:     w_expected = (r_word.op_b == '0) ? '0 : r_word.op_a / r_word.op_b;
            MOD:     w_expected = (r_word.op_b == '0) ? '0 : r_word.op_a % r_word.op_b;
            POW:     w_expected = f_pow(r_word.op_a, r_word.op_b);
            default: w_defined  = 1'b0;
        endcase
        w_mismatch = !w_defined || $isunknown(r_word) || (r_word.result != w_expected);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last       <= '0;
            r_word       <= '0;
            read_pointer <= '0;
            out_valid    <= 1'b0;
            out_word     <= '0;
            out_expected <= '0;
            out_mismatch <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_count    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_last       <= last_ptr;
                        read_pointer <= first_ptr;
                        err_count    <= '0;
                        busy         <= 1'b1;
                        r_state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_word  <= instruction_word;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    out_word     <= r_word;
                    out_expected <= w_expected;
                    out_mismatch <= w_mismatch;
                    out_valid    <= 1'b1;
                    r_state      <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_mismatch && (err_count != c_cnt_max))
                            err_count <= err_count + CNT_W'(1);
                        if (read_pointer == r_last) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            read_pointer <= (read_pointer == c_last_addr) ? '0
                                                                          : read_pointer + address_t'(1);
                            r_state      <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
